// File: rtl/mem_stage_responder_if.sv
// Purpose : MEM-stage <-> data-memory responder request/response bundle.
// Latency : n/a (wires only).
// Backpressure: ready low stalls the requester; request must be held until ready is high.
// Ports   : MEM_R_EN/MEM_W_EN/ALU_Res/Val_Rm from the pipeline; ready/read_data/addr_err back.
interface mem_stage_responder_if;
    localparam int ADDRESS_LEN = 32;

    logic                   MEM_R_EN;
    logic                   MEM_W_EN;
    logic [ADDRESS_LEN-1:0] ALU_Res;
    logic [31:0]            Val_Rm;
    logic                   ready;
    logic [31:0]            read_data;
    logic                   addr_err;

    // Pipeline side: issues requests, observes completion.
    modport master (
        output MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm,
        input  ready, read_data, addr_err
    );

    // Memory side: consumes requests, reports completion.
    modport slave (
        input  MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm,
        output ready, read_data, addr_err
    );
endinterface

// File: rtl/mem_stage_responder.sv
// Purpose : fixed-latency data-memory responder for the MEM stage (word-addressed internal RAM).
// Latency : ready low for WAIT_CYCLES cycles per access; result/addr_err visible in the following DONE cycle.
// Backpressure: ready=0 freezes the pipeline; a request seen in DONE waits for the next IDLE cycle.
// Ports   : clk, rst (sync, active-high), bus (slave modport: request in, ready/read_data/addr_err out).
module mem_stage_responder #(
    parameter int WAIT_CYCLES = 4,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_stage_responder_if.slave   bus
);

    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] BASE     = 32'(BASE_ADDR);
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] read_data_q, read_data_d;
    logic        addr_err_q, addr_err_d;
    logic [31:0] mem_q [DEPTH];

    logic             req;
    logic             ready;
    logic [31:0]      off;
    logic             addr_ok;
    logic [IDX_W-1:0] idx;
    logic             mem_we;

    // Below-base addresses wrap to a huge offset and fail the range test.
    always_comb begin
        off     = addr_q - BASE;
        addr_ok = (off[1:0] == 2'b00) && (off[31:2] < DEPTH_W);
        idx     = off[IDX_W+1:2];
    end

    always_comb begin
        req         = bus.MEM_R_EN | bus.MEM_W_EN;
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        is_wr_d     = is_wr_q;
        read_data_d = read_data_q;
        addr_err_d  = 1'b0;
        mem_we      = 1'b0;
        ready       = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    addr_d  = bus.ALU_Res;
                    wdat_d  = bus.Val_Rm;
                    // Write wins when both enables are set.
                    is_wr_d = bus.MEM_W_EN;
                    cnt_d   = 4'd1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    if (addr_ok) begin
                        if (is_wr_q) mem_we      = 1'b1;
                        else         read_data_d = mem_q[idx];
                    end else begin
                        addr_err_d = 1'b1;
                        if (!is_wr_q) read_data_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                ready   = 1'b1;
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdat_q      <= '0;
            is_wr_q     <= 1'b0;
            read_data_q <= '0;
            addr_err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            is_wr_q     <= is_wr_d;
            read_data_q <= read_data_d;
            addr_err_q  <= addr_err_d;
            if (mem_we) mem_q[idx] <= wdat_q;
        end
    end

    assign bus.ready     = ready;
    assign bus.read_data = read_data_q;
    assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_mem_stage_responder.sv
// Purpose : directed self-checking bench for mem_stage_responder (WAIT_CYCLES=4, DEPTH=64, BASE=1024).
// Latency : each access expected to hold ready low for 4 cycles, results sampled in DONE.
// Backpressure: requests held while ready is low, dropped (or held, where noted) in DONE.
module tb_mem_stage_responder;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    mem_stage_responder_if bus ();

    mem_stage_responder #(
        .WAIT_CYCLES (4),
        .DEPTH       (64),
        .BASE_ADDR   (1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // mode 0: plain; 1: change addr/data after acceptance; 2: drop enables while BUSY;
    // 3: keep the request asserted through DONE.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int mode,
                          output int low, output logic [31:0] rd,
                          output logic err, output logic err_nxt);
        bus.MEM_R_EN = r;
        bus.MEM_W_EN = w;
        bus.ALU_Res  = a;
        bus.Val_Rm   = d;
        low = 0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (bus.ready) break;
            low++;
            @(negedge clk);
            if (low == 1 && mode == 1) begin
                bus.ALU_Res = a + 32'd4;
                bus.Val_Rm  = ~d;
            end
            if (low == 1 && mode == 2) begin
                bus.MEM_R_EN = 1'b0;
                bus.MEM_W_EN = 1'b0;
            end
        end
        chk("done_ready", {31'd0, bus.ready}, 32'd1);
        rd  = bus.read_data;
        err = bus.addr_err;
        if (mode != 3) begin
            bus.MEM_R_EN = 1'b0;
            bus.MEM_W_EN = 1'b0;
        end
        @(negedge clk);
        err_nxt = bus.addr_err;
    endtask

    int          low;
    logic [31:0] rd;
    logic        err, errn;

    initial begin
        n_chk = 0;
        n_pass = 0;
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
        bus.ALU_Res  = '0;
        bus.Val_Rm   = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_rdata", bus.read_data, 32'd0);
        chk("rst_err",   {31'd0, bus.addr_err}, 32'd0);

        access(1, 0, 32'd1024, 32'd0, 0, low, rd, err, errn);
        chk("rd_clr_low", 32'(low), 32'd4);
        chk("rd_clr_dat", rd, 32'd0);
        chk("rd_clr_err", {31'd0, err}, 32'd0);

        access(0, 1, 32'd1024, 32'hDEADBEEF, 0, low, rd, err, errn);
        chk("wr1024_low", 32'(low), 32'd4);
        chk("wr1024_err", {31'd0, err}, 32'd0);
        access(1, 0, 32'd1024, 32'd0, 0, low, rd, err, errn);
        chk("rd1024_low", 32'(low), 32'd4);
        chk("rd1024_dat", rd, 32'hDEADBEEF);

        access(0, 1, 32'd1028, 32'h11, 0, low, rd, err, errn);
        chk("wr1028_err", {31'd0, err}, 32'd0);
        access(0, 1, 32'd1280, 32'h22, 0, low, rd, err, errn);
        chk("wr_oor_low",  32'(low), 32'd4);
        chk("wr_oor_err",  {31'd0, err}, 32'd1);
        chk("wr_oor_errn", {31'd0, errn}, 32'd0);
        chk("wr_oor_rd",   rd, 32'hDEADBEEF);
        access(1, 0, 32'd1028, 32'd0, 0, low, rd, err, errn);
        chk("rd1028_dat", rd, 32'h11);
        access(0, 1, 32'd1276, 32'hAB, 0, low, rd, err, errn);
        chk("wr_last_err", {31'd0, err}, 32'd0);
        access(1, 0, 32'd1276, 32'd0, 0, low, rd, err, errn);
        chk("rd_last_dat", rd, 32'hAB);
        chk("rd_last_err", {31'd0, err}, 32'd0);

        access(1, 0, 32'd1030, 32'd0, 0, low, rd, err, errn);
        chk("rd_mis_low",  32'(low), 32'd4);
        chk("rd_mis_dat",  rd, 32'd0);
        chk("rd_mis_err",  {31'd0, err}, 32'd1);
        chk("rd_mis_errn", {31'd0, errn}, 32'd0);
        access(1, 0, 32'd1024, 32'd0, 0, low, rd, err, errn);
        chk("rd1024_again", rd, 32'hDEADBEEF);
        access(1, 0, 32'd1000, 32'd0, 0, low, rd, err, errn);
        chk("rd_below_dat", rd, 32'd0);
        chk("rd_below_err", {31'd0, err}, 32'd1);

        access(1, 0, 32'd1024, 32'd0, 0, low, rd, err, errn);
        access(1, 1, 32'd1032, 32'h55, 0, low, rd, err, errn);
        chk("both_rd_hold", rd, 32'hDEADBEEF);
        chk("both_err",     {31'd0, err}, 32'd0);
        access(1, 0, 32'd1032, 32'd0, 0, low, rd, err, errn);
        chk("rd1032_dat", rd, 32'h55);

        access(0, 1, 32'd1040, 32'h99, 1, low, rd, err, errn);
        access(1, 0, 32'd1040, 32'd0, 0, low, rd, err, errn);
        chk("latch_dat", rd, 32'h99);
        access(1, 0, 32'd1044, 32'd0, 0, low, rd, err, errn);
        chk("latch_other", rd, 32'd0);

        access(0, 1, 32'd1048, 32'h5A, 2, low, rd, err, errn);
        chk("drop_low", 32'(low), 32'd4);
        access(1, 0, 32'd1048, 32'd0, 3, low, rd, err, errn);
        chk("drop_dat", rd, 32'h5A);
        access(1, 0, 32'd1048, 32'd0, 0, low, rd, err, errn);
        chk("b2b_low", 32'(low), 32'd4);
        chk("b2b_dat", rd, 32'h5A);

        // Reset while a write is in flight: the write must be abandoned.
        bus.MEM_W_EN = 1'b1;
        bus.ALU_Res  = 32'd1036;
        bus.Val_Rm   = 32'h77;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.MEM_W_EN = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", {31'd0, bus.ready}, 32'd1);
        chk("midrst_rdata", bus.read_data, 32'd0);
        @(negedge clk);
        access(1, 0, 32'd1036, 32'd0, 0, low, rd, err, errn);
        chk("midrst_rd1036", rd, 32'd0);
        access(1, 0, 32'd1024, 32'd0, 0, low, rd, err, errn);
        chk("midrst_rd1024", rd, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_stage_responder.md
Name: mem_stage_responder

Overview:
- Memory-side responder for the MEM stage's data-memory requests.
- Accepts a single read or write request, holds it for a fixed, parameterised number of wait cycles, then completes it against an internal word-addressed data memory.
- Drives `ready`, which the top level inverts into the pipeline `freeze`, stalling all stages while an access is outstanding.
- Sits between the MEM stage and MEM_Stage_Reg.

Parameters:
- WAIT_CYCLES, 4, number of cycles `ready` stays low per access; legal range 2..15.
- DEPTH, 64, number of 32-bit words in the internal memory.
- BASE_ADDR, 1024, byte address that maps to word 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- MEM_R_EN  input  1  read request from the MEM stage.
- MEM_W_EN  input  1  write request from the MEM stage.
- ALU_Res  input  `ADDRESS_LEN (32)  byte address of the access.
- Val_Rm  input  32  write data.
- ready  output  1  low while an access is outstanding; high otherwise.
- read_data  output  32  registered read result.
- addr_err  output  1  one-cycle pulse when an access completes out of range or misaligned.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state returns to IDLE, cnt=0, read_data=0, addr_err=0.
  - All DEPTH memory words are cleared to 0.
  - Reset has priority over every other event, including an access in flight; that access is abandoned and any write is not committed.
- Request: req = MEM_R_EN | MEM_W_EN. If both enables are high, the access is a write; the read is ignored.
- ready is combinational: ready = (state==IDLE & ~req) | (state==DONE).
  - The pipeline keeps its request asserted while ready=0.
- State machine (IDLE, BUSY, DONE):
  - IDLE & req: latch the address, write data and kind into internal registers; next state BUSY; cnt=1; ready=0 in this cycle.
  - IDLE & ~req: stay in IDLE; ready=1.
  - BUSY: ready=0. If cnt==WAIT_CYCLES-1, next state is DONE; otherwise cnt increments.
  - DONE: ready=1; next state IDLE; cnt=0.
- Timing of an access:
  - ready is low for exactly WAIT_CYCLES consecutive cycles (the acceptance cycle plus WAIT_CYCLES-1 BUSY cycles).
  - The access occupies WAIT_CYCLES+1 cycles in total.
- Address decode, computed from the latched address:
  - off = addr - BASE_ADDR, as 32-bit unsigned arithmetic.
  - Valid if off[1:0]==0 and off[31:2] < DEPTH; word index = off[31:2].
  - An address below BASE_ADDR wraps to a large off and is therefore invalid.
- Completion, at the edge that moves BUSY to DONE:
  - Valid read: read_data <= mem[index].
  - Invalid read: read_data <= 0.
  - Valid write: mem[index] <= latched data; read_data is unchanged.
  - Invalid write: memory is unchanged.
  - addr_err <= 1 for one cycle (the DONE cycle) on any invalid access; 0 otherwise.
- Output hold: read_data holds its value until the next read completes, or until reset.
- Back-to-back accesses: a new request seen in DONE is not accepted; it is accepted in the following IDLE cycle.
  - The minimum gap between acceptances is WAIT_CYCLES+1 cycles.
- Input changes: MEM_R_EN, MEM_W_EN, ALU_Res and Val_Rm changing after acceptance have no effect on the access in flight.
- Request dropped mid-access (enables fall while BUSY): the access still completes normally.

Test Plan:
- Reset, then idle with no request → ready=1, read_data=0, addr_err=0; a read of BASE_ADDR returns 0 (memory cleared).
- Write 0xDEADBEEF to address 1024 with WAIT_CYCLES=4 → ready low for exactly 4 cycles and high on the 5th; then read 1024 → read_data=0xDEADBEEF in the DONE cycle, again after 4 low cycles.
- Write 0x11 to 1028 and 0x22 to 1280 (word 64, out of range) → second access pulses addr_err for 1 cycle; read 1028 = 0x11; memory elsewhere unchanged.
- Misaligned read of 1030 and read of 1000 (below base) → both complete with read_data=0 and an addr_err pulse; ready timing unchanged.
- MEM_R_EN and MEM_W_EN both high, address 1032, data 0x55 → treated as a write; a subsequent read of 1032 = 0x55; read_data is not updated by the combined access.
- Assert rst during the BUSY of a write of 0x77 to 1036 → next cycle ready=1, state IDLE; a later read of 1036 returns 0.
